// File: rtl/fp_linear_decoder_pkg.sv
// Shared widths and FSM encoding for the 8-bit float to 12-bit linear decoder.
package fp_linear_decoder_pkg;

  localparam int unsigned DefWLin = 12;
  localparam int unsigned DefWExp = 3;
  localparam int unsigned DefWSig = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StHold  = 2'd2
  } state_e;

endpackage

// File: rtl/fp_linear_decoder_sign_apply.sv
// Applies the float sign to an unsigned magnitude; zero magnitude never yields negative zero.
module fp_linear_decoder_sign_apply #(
  parameter int unsigned W_LIN = 12
) (
  input  logic             i_sgn,
  input  logic [W_LIN-1:0] i_mag,
  output logic [W_LIN-1:0] o_val
);

  always_comb begin
    o_val = i_mag;
    if (i_mag == '0) begin
      o_val = '0;
    end else if (i_sgn) begin
      o_val = -i_mag;
    end
  end

endmodule

// File: rtl/fp_linear_decoder.sv
// Sequential float {sign, exp, sig} to two's-complement linear expander with
// ready/valid handshakes: one significand shift per clock, then sign applied.
module fp_linear_decoder
  import fp_linear_decoder_pkg::*;
#(
  parameter int unsigned W_LIN = DefWLin,
  parameter int unsigned W_EXP = DefWExp,
  parameter int unsigned W_SIG = DefWSig
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [W_EXP-1:0] in_exp,
  input  logic [W_SIG-1:0] in_sig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_LIN-1:0] dout,
  output logic             busy
);

  state_e r_state, w_state_next;

  logic             r_sgn;
  logic [W_EXP-1:0] r_cnt;
  logic [W_LIN-1:0] r_mag;
  logic [W_LIN-1:0] r_dout;
  logic             r_out_valid;
  logic [W_LIN-1:0] w_signed;

  fp_linear_decoder_sign_apply #(
    .W_LIN (W_LIN)
  ) u_sign_apply (
    .i_sgn (r_sgn),
    .i_mag (r_mag),
    .o_val (w_signed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_next = StShift;
      StShift: if (r_cnt == '0) w_state_next = StHold;
      StHold:  if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // in_ready is gated by rst_n so it reads low for the whole reset pulse.
  always_comb begin
    in_ready  = rst_n && (r_state == StIdle);
    busy      = (r_state != StIdle);
    out_valid = r_out_valid;
    dout      = r_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sgn       <= 1'b0;
      r_cnt       <= '0;
      r_mag       <= '0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_sgn <= in_sign;
            r_cnt <= in_exp;
            r_mag <= W_LIN'(in_sig);
          end
        end
        StShift: begin
          if (r_cnt != '0) begin
            r_mag <= r_mag << 1;
            r_cnt <= r_cnt - W_EXP'(1);
          end else begin
            r_dout      <= w_signed;
            r_out_valid <= 1'b1;
          end
        end
        StHold: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_linear_decoder.sv
// Scoreboard bench for fp_linear_decoder: expected values queued at accept,
// compared when out_valid appears; covers latency, HOLD stall and mid-SHIFT reset.
module tb_fp_linear_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [2:0]  in_exp;
  logic [3:0]  in_sig;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] dout;
  logic        busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];

  fp_linear_decoder u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_sig    (in_sig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [11:0] model(input bit s, input int e, input int g);
    int v;
    v = g * (1 << e);
    if (s) v = -v;
    return 12'(v);
  endfunction

  // Waits for in_ready, drives one float and pushes its expected result.
  task automatic accept(input bit s, input int e, input int g, output bit ok);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    ok = in_ready;
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    in_sign  = s;
    in_exp   = 3'(e);
    in_sig   = 4'(g);
    in_valid = 1'b1;
    exp_q.push_back(model(s, e, g));
    @(posedge clk);
  endtask

  // poke: keep in_valid high with different data while SHIFT runs (must be ignored).
  task automatic txn(input bit s, input int e, input int g, input int stall, input bit poke);
    bit          ok;
    bit          got_it;
    int          lat;
    logic [11:0] want;
    accept(s, e, g, ok);
    if (!ok) return;
    @(negedge clk);
    if (poke) begin
      in_sign = ~in_sign;
      in_exp  = ~in_exp;
      in_sig  = ~in_sig;
    end else begin
      in_valid = 1'b0;
    end
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("in_ready_in_shift", {31'd0, in_ready}, 32'd0);
    lat    = 0;
    got_it = 1'b0;
    while (!got_it && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 2) in_valid = 1'b0;
      if (out_valid) got_it = 1'b1;
    end
    in_valid = 1'b0;
    if (!got_it) begin
      check("out_valid_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    want = exp_q.pop_front();
    check("dout", {20'd0, dout}, {20'd0, want});
    check("latency", lat, e + 1);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_dout", {20'd0, dout}, {20'd0, want});
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    check("in_ready_hold_exit", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_after_take", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_take", {31'd0, in_ready}, 32'd1);
    check("busy_after_take", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bit ok;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_sig    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_dout", {20'd0, dout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed cases, then the 5-clock HOLD stall and an ignored in_valid during SHIFT.
    txn(1'b0, 0, 0, 0, 1'b0);
    txn(1'b0, 7, 15, 0, 1'b0);
    check("dir_1920", {20'd0, model(1'b0, 7, 15)}, 32'h780);
    txn(1'b1, 3, 10, 0, 1'b0);
    txn(1'b1, 0, 0, 0, 1'b0);
    txn(1'b0, 2, 5, 5, 1'b0);
    txn(1'b1, 5, 3, 0, 1'b1);
    txn(1'b0, 4, 1, 0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      txn(bit'($urandom_range(1)), int'($urandom_range(7)), int'($urandom_range(15)),
          int'($urandom_range(2)), 1'b0);
    end

    // Reset in the middle of SHIFT discards the queued result.
    accept(1'b0, 6, 9, ok);
    if (ok) begin
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_dout", {20'd0, dout}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      void'(exp_q.pop_front());
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrst_rel_in_ready", {31'd0, in_ready}, 32'd1);
      txn(1'b0, 1, 3, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
